// File: rtl/onchip_ram_pkg.sv
// -----------------------------------------------------------------------------
// onchip_ram_pkg
// Shared constants and types for the on-chip SRAM arbiter and its helpers.
//   RAM_AW / RAM_DW / RAM_SW : word-address, data and strobe widths of the
//                              128KB macro (32K words of 32 bits).
//   RAM_WORDS                : number of 32-bit words in the macro.
//   arb_state_e              : arbiter FSM states (INIT only used when the
//                              zeroize sweep is built).
//   idx_width()              : width of an index into an n-entry vector,
//                              never narrower than one bit.
// -----------------------------------------------------------------------------
package onchip_ram_pkg;

   localparam int RAM_AW    = 15;
   localparam int RAM_DW    = 32;
   localparam int RAM_SW    = 4;
   localparam int RAM_WORDS = 32768;

   typedef enum logic {
      ARB_INIT,
      ARB_RUN
   } arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onchip_ram_rr_arb.sv
// -----------------------------------------------------------------------------
// onchip_ram_rr_arb
// Combinational round-robin picker, shared by the slaves that front a single
// resource. The winner is the first asserted request at an index >= ptr_i,
// wrapping modulo NUM_REQ.
// Ports:
//   req_i   in  NUM_REQ  request vector
//   ptr_i   in  IW       highest-priority index for this cycle (< NUM_REQ)
//   grant_o out NUM_REQ  one-hot grant, all-zero when req_i is all-zero
//   idx_o   out IW       index of the winner (0 when nothing is requested)
// -----------------------------------------------------------------------------
module onchip_ram_rr_arb
   import onchip_ram_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   // Walk the requesters starting at ptr_i; the first hit wins and later
   // candidates are masked by 'found'.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((32'(ptr_i) + 32'(k)) % 32'(NUM_REQ));
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = cand;
         end
      end
   end

endmodule

// File: rtl/onchip_ram_arb.sv
// -----------------------------------------------------------------------------
// onchip_ram_arb
// Shares the single-port 128KB on-chip SRAM between NUM_REQ bus masters.
// One access per cycle is granted round-robin; the RAM is driven
// combinationally from the winner and a one-hot response strobe follows one
// cycle after every accept (reads and writes alike). Read data is the RAM
// output passed straight through.
//
// Build option: define ONCHIP_RAM_ARB_ZEROIZE_EN to sweep the whole RAM with
// zeros after reset (INIT state, 2**RAM_AW cycles) before traffic is accepted.
// Without it the FSM resets straight into RUN and init_done_o is tied high.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o per-requester handshake (ready is one-hot grant)
//   req_addr_i          byte address; only bits [RAM_AW+1:2] are used
//   req_wdata_i/wstrb_i write data and byte strobes (strobe 0 = read)
//   rsp_valid_o         one-hot response, one cycle after accept
//   rsp_rdata_o         read data shared by all requesters
//   ram_en_o/addr_o/wdata_o/wstrb_o/rdata_i   RAM macro interface
//   init_done_o         arbiter is accepting traffic
// -----------------------------------------------------------------------------
module onchip_ram_arb #(
   parameter int NUM_REQ = 2,
   parameter int RAM_AW  = 15
) (
   input  logic                                           clk_i,
   input  logic                                           rst_i,
   input  logic [NUM_REQ-1:0]                             req_valid_i,
   output logic [NUM_REQ-1:0]                             req_ready_o,
   input  logic [NUM_REQ-1:0][31:0]                       req_addr_i,
   input  logic [NUM_REQ-1:0][onchip_ram_pkg::RAM_DW-1:0] req_wdata_i,
   input  logic [NUM_REQ-1:0][onchip_ram_pkg::RAM_SW-1:0] req_wstrb_i,
   output logic [NUM_REQ-1:0]                             rsp_valid_o,
   output logic [onchip_ram_pkg::RAM_DW-1:0]              rsp_rdata_o,
   output logic                                           ram_en_o,
   output logic [RAM_AW-1:0]                              ram_addr_o,
   output logic [onchip_ram_pkg::RAM_DW-1:0]              ram_wdata_o,
   output logic [onchip_ram_pkg::RAM_SW-1:0]              ram_wstrb_o,
   input  logic [onchip_ram_pkg::RAM_DW-1:0]              ram_rdata_i,
   output logic                                           init_done_o
);

   import onchip_ram_pkg::*;

   localparam int IW = idx_width(NUM_REQ);

`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
   localparam arb_state_e RESET_STATE = ARB_INIT;
`else
   localparam arb_state_e RESET_STATE = ARB_RUN;
`endif

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      winner;
   logic               any_valid;

`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
   logic [RAM_AW-1:0]  cnt_q, cnt_d;
`endif

   // Byte-offset and out-of-range address bits are deliberately dropped; the
   // upstream decoder owns range checking.
   logic [NUM_REQ-1:0] unused_addr_bits;
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unused
      assign unused_addr_bits[gi] = ^{req_addr_i[gi][31:RAM_AW+2], req_addr_i[gi][1:0]};
   end

   assign any_valid = |req_valid_i;

   onchip_ram_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_arb (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (winner)
   );

   // ---------------------------------------------------------------------------
   // Next-state and outputs. While rst_i is held everything RAM- and
   // requester-facing stays quiet so nothing is accepted during reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rsp_valid_d = '0;
      req_ready_o = '0;
      ram_en_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_wstrb_o = '0;
`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
      cnt_d       = cnt_q;
`endif

      if (!rst_i) begin
         unique case (state_q)
            ARB_INIT: begin
`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
               // Zero one word per cycle; leave after the last word.
               ram_en_o    = 1'b1;
               ram_addr_o  = cnt_q;
               ram_wstrb_o = '1;
               cnt_d       = cnt_q + RAM_AW'(1);
               if (cnt_q == '1) begin
                  state_d = ARB_RUN;
               end
`else
               state_d = ARB_RUN;
`endif
            end

            ARB_RUN: begin
               // A valid request always wins somebody, so every valid cycle
               // is an accept and the RAM is driven from the winner.
               if (any_valid) begin
                  req_ready_o = grant;
                  ram_en_o    = 1'b1;
                  ram_addr_o  = req_addr_i[winner][RAM_AW+1:2];
                  ram_wdata_o = req_wdata_i[winner];
                  ram_wstrb_o = req_wstrb_i[winner];
                  rsp_valid_d = grant;
                  if (winner == IW'(NUM_REQ - 1)) begin
                     ptr_d = '0;
                  end else begin
                     ptr_d = winner + IW'(1);
                  end
               end
            end

            default: begin
               state_d = RESET_STATE;
            end
         endcase
      end
   end

   // Reset drops any response still in flight and rewinds the pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RESET_STATE;
         ptr_q       <= '0;
         rsp_valid_q <= '0;
`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = ram_rdata_i;

`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
   assign init_done_o = (state_q == ARB_RUN);
`else
   assign init_done_o = 1'b1;
`endif

endmodule

// File: tb/tb_onchip_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_onchip_ram_arb
// Randomised and directed traffic into onchip_ram_arb (3 requesters) with a
// behavioural RAM, a golden memory image and a response scoreboard. The
// driver predicts each grant from the round-robin rule and queues the
// expected response; an independent monitor pops and compares responses.
// -----------------------------------------------------------------------------
module tb_onchip_ram_arb;

   localparam int NR    = 3;
   localparam int AW    = 15;
   localparam int WORDS = 32768;

`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
   localparam logic INIT_DONE_RST = 1'b0;
`else
   localparam logic INIT_DONE_RST = 1'b1;
`endif

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b0;
   logic [NR-1:0]       req_valid_i;
   logic [NR-1:0]       req_ready_o;
   logic [NR-1:0][31:0] req_addr_i;
   logic [NR-1:0][31:0] req_wdata_i;
   logic [NR-1:0][3:0]  req_wstrb_i;
   logic [NR-1:0]       rsp_valid_o;
   logic [31:0]         rsp_rdata_o;
   logic                ram_en_o;
   logic [AW-1:0]       ram_addr_o;
   logic [31:0]         ram_wdata_o;
   logic [3:0]          ram_wstrb_o;
   logic [31:0]         ram_rdata_i = '0;
   logic                init_done_o;

   onchip_ram_arb #(.NUM_REQ(NR), .RAM_AW(AW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_wstrb_i (req_wstrb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_wstrb_o (ram_wstrb_o),
      .ram_rdata_i (ram_rdata_i),
      .init_done_o (init_done_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Behavioural single-port RAM: registered read, byte-strobed write.
   logic [31:0] mem [WORDS];
   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = pat(i);
      forever begin
         @(posedge clk_i);
         if (ram_en_o) begin
            ram_rdata_i = mem[ram_addr_o];
            for (int b = 0; b < 4; b++)
               if (ram_wstrb_o[b]) mem[ram_addr_o][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Reference state and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      int          idx;
      bit          rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] gold [WORDS];
   logic [NR-1:0] pv = '0;
   logic [31:0] pa [NR];
   logic [31:0] pd [NR];
   logic [3:0]  ps [NR];
   int          ptr_m  = 0;
   int          last_w = -1;
   int          tests  = 0;
   int          fails  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Round-robin rule: first valid index at or after p, wrapping.
   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++)
         if (v[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   task automatic apply();
      for (int r = 0; r < NR; r++) begin
         req_valid_i[r] = pv[r];
         req_addr_i[r]  = pa[r];
         req_wdata_i[r] = pd[r];
         req_wstrb_i[r] = ps[r];
      end
   endtask

   task automatic issue(input int r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      pv[r] = 1'b1;
      pa[r] = a;
      pd[r] = d;
      ps[r] = s;
      apply();
   endtask

   task automatic rand_issue(input int r);
      logic [14:0] pool [8];
      logic [14:0] w;
      logic [31:0] a;
      logic [3:0]  s;
      pool = '{15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h0400, 15'h0801, 15'h4000, 15'h7FFF};
      w = pool[$urandom_range(0, 7)];
      a = ($urandom & 32'hFFFE_0000) | (32'(w) << 2) | ($urandom & 32'h3);
      s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      issue(r, a, $urandom, s);
   endtask

   // One clock: predict and check the grant at the falling edge, queue the
   // expected response, then advance past the rising edge.
   task automatic step();
      int   w;
      int   wi;
      exp_t e;
      @(negedge clk_i);
      w = pick(pv, ptr_m);
      last_w = w;
      if (w < 0) begin
         chk("ready_idle", 64'(req_ready_o), 64'(0));
         chk("ram_en_idle", 64'(ram_en_o), 64'(0));
      end else begin
         wi = int'(pa[w][16:2]);
         chk("ready", 64'(req_ready_o), 64'(1) << w);
         chk("ram_en", 64'(ram_en_o), 64'(1));
         chk("ram_addr", 64'(ram_addr_o), 64'(wi));
         chk("ram_wdata", 64'(ram_wdata_o), 64'(pd[w]));
         chk("ram_wstrb", 64'(ram_wstrb_o), 64'(ps[w]));
         e.idx  = w;
         e.rd   = (ps[w] == 4'h0);
         e.data = gold[wi];
         e.due  = cyc + 1;
         q.push_back(e);
         for (int b = 0; b < 4; b++)
            if (ps[w][b]) gold[wi][b*8 +: 8] = pd[w][b*8 +: 8];
         pv[w] = 1'b0;
         ptr_m = (w + 1) % NR;
      end
      @(posedge clk_i);
      #1;
      apply();
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && pv != '0; i++) step();
      chk("drain_pending", 64'(pv), 64'(0));
      step();
      step();
   endtask

   task automatic do_reset();
      int n;
      rst_i = 1'b1;
      q.delete();
      pv = '0;
      apply();
      req_valid_i = '1;   // raw requests that must be ignored during reset
      @(negedge clk_i);
      chk("rst_ready", 64'(req_ready_o), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_ram_en", 64'(ram_en_o), 64'(0));
      chk("rst_ram_addr", 64'(ram_addr_o), 64'(0));
      chk("rst_ram_wdata", 64'(ram_wdata_o), 64'(0));
      chk("rst_ram_wstrb", 64'(ram_wstrb_o), 64'(0));
      chk("rst_init_done", 64'(init_done_o), 64'(INIT_DONE_RST));
      chk("rst_rdata_pass", 64'(rsp_rdata_o), 64'(ram_rdata_i));
      rst_i  = 1'b0;
      ptr_m  = 0;
      last_w = -1;
      apply();
`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
      n = 0;
      req_valid_i = '1;
      while (!init_done_o && n < 40000) begin
         chk("init_ready", 64'(req_ready_o), 64'(0));
         chk("init_addr", 64'(ram_addr_o), 64'(n % WORDS));
         chk("init_wstrb", 64'(ram_wstrb_o), 64'hF);
         chk("init_wdata", 64'(ram_wdata_o), 64'(0));
         n++;
         @(negedge clk_i);
      end
      chk("init_cycles", 64'(n), 64'(WORDS));
      for (int i = 0; i < WORDS; i++) gold[i] = '0;
      apply();
`else
      n = 0;
      chk("init_done_run", 64'(init_done_o), 64'(1));
`endif
      @(posedge clk_i);
      #1;
   endtask

   // Response monitor: one comparison per cycle against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", 64'(rsp_valid_o), 64'(1) << e.idx);
            if (e.rd) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.data));
            $display("[TB] rsp req%0d %s data=0x%08h", e.idx, e.rd ? "rd" : "wr", rsp_rdata_o);
         end else begin
            chk("rsp_idle", 64'(rsp_valid_o), 64'(0));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int p0;
      for (int r = 0; r < NR; r++) begin
         pa[r] = '0;
         pd[r] = '0;
         ps[r] = '0;
      end
      for (int i = 0; i < WORDS; i++) gold[i] = pat(i);
      apply();
      do_reset();

      // Hold stability: req0 wins (ptr 0), req1 holds and reads req0's write.
      issue(0, 32'h0000_3000, 32'hCAFE_F00D, 4'hF);
      issue(1, 32'h0000_3000, 32'h1234_5678, 4'h0);
      step();
      chk("hold_first", 64'(last_w), 64'(0));
      step();
      chk("hold_second", 64'(last_w), 64'(1));
      drain();

`ifdef ONCHIP_RAM_ARB_ZEROIZE_EN
      issue(0, 32'h0000_0000, 32'h0, 4'h0); step();
      issue(0, 32'h0001_0000, 32'h0, 4'h0); step();
      issue(0, 32'h0001_FFFC, 32'h0, 4'h0); step();
      drain();
`endif

      // Single requester write then read back.
      issue(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF); step();
      issue(0, 32'h0000_1000, 32'h0, 4'h0);         step();
      drain();

      // Byte strobes.
      issue(0, 32'h0000_2004, 32'h1122_3344, 4'hF); step();
      issue(0, 32'h0000_2004, 32'h0000_00AA, 4'h1); step();
      issue(0, 32'h0000_2004, 32'h0, 4'h0);         step();
      drain();

      // Random traffic from all requesters.
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < NR; r++)
            if (!pv[r] && $urandom_range(0, 1) == 1) rand_issue(r);
         step();
      end
      drain();

      // Reset in the response cycle of an accept, then contention from reset.
      issue(0, 32'h0000_0100, 32'h0A0A_0A0A, 4'hF);
      issue(1, 32'h0000_0104, 32'h0B0B_0B0B, 4'hF);
      step();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (!pv[0]) rand_issue(0);
         if (!pv[1]) rand_issue(1);
         step();
         chk("alternate", 64'(last_w), 64'(i % 2));
      end
      drain();

      // Fairness with every requester continuously valid.
      p0 = ptr_m;
      for (int i = 0; i < 3 * NR; i++) begin
         for (int r = 0; r < NR; r++)
            if (!pv[r]) rand_issue(r);
         step();
         chk("fair", 64'(last_w), 64'((p0 + i) % NR));
      end
      drain();

      // Lone requester is granted every cycle whatever the pointer.
      for (int i = 0; i < 4; i++) begin
         rand_issue(NR - 1);
         step();
         chk("single", 64'(last_w), 64'(NR - 1));
      end
      drain();
      chk("scoreboard_empty", 64'(q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
